// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares one sdram_ctrl read/write request interface between two client ports.
// There are four requesters: 0=P0W, 1=P0R, 2=P1W, 3=P1R. One burst is granted at a time.
// Each grant is latched (id, addr, burst_len) and the matching m_*_req is raised one cycle later.
// The burst ends when the controller's ack falls. A single REL cycle follows, and then the
// round-robin pointer moves past the finished requester.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   p{0,1}_wr_req/addr/burst_len   client write request and its attributes
//   p{0,1}_wr_data                 client write data; muxed to m_wr_data with zero latency
//   p{0,1}_wr_ack, p{0,1}_rd_ack   controller acks, routed to the granted requester only
//   p{0,1}_rd_req/addr/burst_len   client read request and its attributes
//   p{0,1}_rd_data                 m_rd_data broadcast to both ports
//   m_{wr,rd}_req/addr/burst_len   request to sdram_ctrl, with latched attributes
//   m_wr_data                      write data of the granted port
//   m_{wr,rd}_ack, m_rd_data       from sdram_ctrl
//   grant_id                       currently granted requester
//   busy                           high whenever the FSM is not idle
//   timeout_err                    one-cycle pulse when a request is aborted for lack of ack
//
// Build option: ARB_RD_PRIORITY_EN. When defined, any pending read beats any pending write.
// Round-robin still applies within each class.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LEN_W       = 10,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_wr_req,
  input  logic [ADDR_W-1:0] p0_wr_addr,
  input  logic [LEN_W-1:0]  p0_wr_burst_len,
  input  logic [DATA_W-1:0] p0_wr_data,
  output logic              p0_wr_ack,
  input  logic              p0_rd_req,
  input  logic [ADDR_W-1:0] p0_rd_addr,
  input  logic [LEN_W-1:0]  p0_rd_burst_len,
  output logic [DATA_W-1:0] p0_rd_data,
  output logic              p0_rd_ack,
  input  logic              p1_wr_req,
  input  logic [ADDR_W-1:0] p1_wr_addr,
  input  logic [LEN_W-1:0]  p1_wr_burst_len,
  input  logic [DATA_W-1:0] p1_wr_data,
  output logic              p1_wr_ack,
  input  logic              p1_rd_req,
  input  logic [ADDR_W-1:0] p1_rd_addr,
  input  logic [LEN_W-1:0]  p1_rd_burst_len,
  output logic [DATA_W-1:0] p1_rd_data,
  output logic              p1_rd_ack,
  output logic              m_wr_req,
  output logic [ADDR_W-1:0] m_wr_addr,
  output logic [LEN_W-1:0]  m_wr_burst_len,
  output logic [DATA_W-1:0] m_wr_data,
  input  logic              m_wr_ack,
  output logic              m_rd_req,
  output logic [ADDR_W-1:0] m_rd_addr,
  output logic [LEN_W-1:0]  m_rd_burst_len,
  input  logic              m_rd_ack,
  input  logic [DATA_W-1:0] m_rd_data,
  output logic [1:0]        grant_id,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StRel} state_e;

  state_e            state_q, state_d;
  logic [1:0]        rr_q, rr_d;
  logic [1:0]        grant_id_q, grant_id_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              m_wr_req_q, m_wr_req_d;
  logic              m_rd_req_q, m_rd_req_d;
  logic [ADDR_W-1:0] m_wr_addr_q, m_wr_addr_d;
  logic [ADDR_W-1:0] m_rd_addr_q, m_rd_addr_d;
  logic [LEN_W-1:0]  m_wr_len_q, m_wr_len_d;
  logic [LEN_W-1:0]  m_rd_len_q, m_rd_len_d;
  logic              timeout_err_q, timeout_err_d;

  logic [3:0] req_vec;
  logic [3:0] cand;
  logic       pick_valid;
  logic [1:0] pick_id;
  logic [1:0] idx;
  logic       ack_g;
  logic       route_en;

  assign req_vec = {p1_rd_req, p1_wr_req, p0_rd_req, p0_wr_req};
  // Bit 0 of an id selects read, and bit 1 selects the port.
  assign ack_g   = grant_id_q[0] ? m_rd_ack : m_wr_ack;

  // Search from rr upward (mod 4). The loop runs downward so the smallest offset wins.
  always_comb begin
    cand = req_vec;
`ifdef ARB_RD_PRIORITY_EN
    if ((req_vec & 4'b1010) != 4'b0000) cand = req_vec & 4'b1010;
`endif
    pick_valid = 1'b0;
    pick_id    = rr_q;
    idx        = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = rr_q + 2'(i);
      if (cand[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    grant_id_d    = grant_id_q;
    cnt_d         = cnt_q;
    m_wr_req_d    = m_wr_req_q;
    m_rd_req_d    = m_rd_req_q;
    m_wr_addr_d   = m_wr_addr_q;
    m_rd_addr_d   = m_rd_addr_q;
    m_wr_len_d    = m_wr_len_q;
    m_rd_len_d    = m_rd_len_q;
    timeout_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_id_d = pick_id;
          cnt_d      = '0;
          state_d    = StReq;
          if (pick_id[0]) begin
            m_rd_req_d  = 1'b1;
            m_rd_addr_d = pick_id[1] ? p1_rd_addr : p0_rd_addr;
            m_rd_len_d  = pick_id[1] ? p1_rd_burst_len : p0_rd_burst_len;
          end else begin
            m_wr_req_d  = 1'b1;
            m_wr_addr_d = pick_id[1] ? p1_wr_addr : p0_wr_addr;
            m_wr_len_d  = pick_id[1] ? p1_wr_burst_len : p0_wr_burst_len;
          end
        end
      end
      StReq: begin
        if (ack_g) begin
          m_wr_req_d = 1'b0;
          m_rd_req_d = 1'b0;
          state_d    = StXfer;
        end else if (!req_vec[grant_id_q]) begin
          // The client withdrew its request, so abort without advancing rr.
          m_wr_req_d = 1'b0;
          m_rd_req_d = 1'b0;
          state_d    = StIdle;
        end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
          m_wr_req_d    = 1'b0;
          m_rd_req_d    = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StXfer: begin
        if (!ack_g) state_d = StRel;
      end
      StRel: begin
        rr_d    = grant_id_q + 2'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rr_q          <= 2'd0;
      grant_id_q    <= 2'd0;
      cnt_q         <= '0;
      m_wr_req_q    <= 1'b0;
      m_rd_req_q    <= 1'b0;
      m_wr_addr_q   <= '0;
      m_rd_addr_q   <= '0;
      m_wr_len_q    <= '0;
      m_rd_len_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      grant_id_q    <= grant_id_d;
      cnt_q         <= cnt_d;
      m_wr_req_q    <= m_wr_req_d;
      m_rd_req_q    <= m_rd_req_d;
      m_wr_addr_q   <= m_wr_addr_d;
      m_rd_addr_q   <= m_rd_addr_d;
      m_wr_len_q    <= m_wr_len_d;
      m_rd_len_q    <= m_rd_len_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Acks reach a client only while its grant is live, so stray acks are dropped.
  assign route_en  = (state_q == StReq) || (state_q == StXfer);
  assign p0_wr_ack = route_en && (grant_id_q == 2'd0) && m_wr_ack;
  assign p0_rd_ack = route_en && (grant_id_q == 2'd1) && m_rd_ack;
  assign p1_wr_ack = route_en && (grant_id_q == 2'd2) && m_wr_ack;
  assign p1_rd_ack = route_en && (grant_id_q == 2'd3) && m_rd_ack;

  assign p0_rd_data     = m_rd_data;
  assign p1_rd_data     = m_rd_data;
  assign m_wr_data      = grant_id_q[1] ? p1_wr_data : p0_wr_data;
  assign m_wr_req       = m_wr_req_q;
  assign m_rd_req       = m_rd_req_q;
  assign m_wr_addr      = m_wr_addr_q;
  assign m_rd_addr      = m_rd_addr_q;
  assign m_wr_burst_len = m_wr_len_q;
  assign m_rd_burst_len = m_rd_len_q;
  assign grant_id       = grant_id_q;
  assign busy           = (state_q != StIdle);
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Testbench for sdram_port_arbiter. The bench plays sdram_ctrl and all four clients.
// A transaction-level model predicts each grant from the pending set and the round-robin pointer.
module tb_sdram_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  req_v;
  logic [23:0] addr_v [4];
  logic [9:0]  len_v  [4];
  logic [15:0] wd_v   [2];
  logic        m_wr_ack, m_rd_ack;
  logic [15:0] m_rd_data;

  logic        p0_wr_ack, p0_rd_ack, p1_wr_ack, p1_rd_ack;
  logic [15:0] p0_rd_data, p1_rd_data, m_wr_data;
  logic        m_wr_req, m_rd_req, busy, timeout_err;
  logic [23:0] m_wr_addr, m_rd_addr;
  logic [9:0]  m_wr_burst_len, m_rd_burst_len;
  logic [1:0]  grant_id;

  int passed = 0;
  int total  = 0;
  int mrr    = 0;

  sdram_port_arbiter #(
    .ADDR_W(24), .DATA_W(16), .LEN_W(10), .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_wr_req(req_v[0]), .p0_wr_addr(addr_v[0]), .p0_wr_burst_len(len_v[0]),
    .p0_wr_data(wd_v[0]), .p0_wr_ack(p0_wr_ack),
    .p0_rd_req(req_v[1]), .p0_rd_addr(addr_v[1]), .p0_rd_burst_len(len_v[1]),
    .p0_rd_data(p0_rd_data), .p0_rd_ack(p0_rd_ack),
    .p1_wr_req(req_v[2]), .p1_wr_addr(addr_v[2]), .p1_wr_burst_len(len_v[2]),
    .p1_wr_data(wd_v[1]), .p1_wr_ack(p1_wr_ack),
    .p1_rd_req(req_v[3]), .p1_rd_addr(addr_v[3]), .p1_rd_burst_len(len_v[3]),
    .p1_rd_data(p1_rd_data), .p1_rd_ack(p1_rd_ack),
    .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_burst_len(m_wr_burst_len),
    .m_wr_data(m_wr_data), .m_wr_ack(m_wr_ack),
    .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_burst_len(m_rd_burst_len),
    .m_rd_ack(m_rd_ack), .m_rd_data(m_rd_data),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  // Reference arbitration: the first pending requester at or after rr, mod 4.
  function automatic int pick(input logic [3:0] m, input int rr);
    logic [3:0] mm;
    mm = m;
`ifdef ARB_RD_PRIORITY_EN
    if ((m & 4'b1010) != 4'b0000) mm = m & 4'b1010;
`endif
    for (int i = 0; i < 4; i++) if (mm[(rr + i) % 4]) return (rr + i) % 4;
    return -1;
  endfunction

  // Waits for a request, acks it after dly cycles, holds the ack alen cycles, then releases it.
  // Returns the observed grant, and counts routing and hold violations in bad.
  task automatic run_burst(input int dly, input int alen, output bit found, output int lat,
                           output int g, output bit is_rd, output logic [23:0] a,
                           output logic [9:0] l, output int bad);
    logic [3:0] obs;
    logic [3:0] exp_v;
    found = 1'b0; lat = 0; g = -1; is_rd = 1'b0; a = '0; l = '0; bad = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      lat = i + 1;
      if (m_wr_req || m_rd_req) found = 1'b1;
    end
    if (!found) return;
    g     = int'(grant_id);
    is_rd = m_rd_req;
    a     = is_rd ? m_rd_addr : m_wr_addr;
    l     = is_rd ? m_rd_burst_len : m_wr_burst_len;
    if (m_wr_req && m_rd_req) bad++;
    if (busy !== 1'b1) bad++;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if ((is_rd ? m_rd_req : m_wr_req) !== 1'b1) bad++;
    end
    if (is_rd) m_rd_ack = 1'b1;
    else       m_wr_ack = 1'b1;
    for (int k = 0; k < alen; k++) begin
      if (k == 1) begin
        addr_v[g] = 24'h0FFFFF;
        len_v[g]  = 10'h3FF;
      end
      wd_v[0]   = 16'($urandom);
      wd_v[1]   = 16'($urandom);
      m_rd_data = 16'($urandom);
      #1;
      exp_v = 4'b0001 << g;
      obs   = {p1_rd_ack, p1_wr_ack, p0_rd_ack, p0_wr_ack};
      if (obs !== exp_v) bad++;
      if (k > 0 && (m_wr_req || m_rd_req)) bad++;
      if ((is_rd ? m_rd_addr : m_wr_addr) !== a) bad++;
      if ((is_rd ? m_rd_burst_len : m_wr_burst_len) !== l) bad++;
      if (!is_rd && m_wr_data !== wd_v[g / 2]) bad++;
      if (p0_rd_data !== m_rd_data || p1_rd_data !== m_rd_data) bad++;
      @(negedge clk);
    end
    m_wr_ack = 1'b0;
    m_rd_ack = 1'b0;
    #1;
    obs = {p1_rd_ack, p1_wr_ack, p0_rd_ack, p0_wr_ack};
    if (obs !== 4'b0000) bad++;
    @(negedge clk);
    if (busy !== 1'b1 || m_wr_req || m_rd_req) bad++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_v = '0; m_wr_ack = 1'b0; m_rd_ack = 1'b0; m_rd_data = '0;
    for (int i = 0; i < 4; i++) begin
      addr_v[i] = 24'($urandom);
      len_v[i]  = 10'($urandom);
    end
    wd_v[0] = '0; wd_v[1] = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({m_wr_req, m_rd_req, busy, grant_id, timeout_err, p0_wr_ack, p0_rd_ack, p1_wr_ack,
         p1_rd_ack} !== 11'd0) begin
      $display("FAIL reset_ctrl: got %b want 0", {m_wr_req, m_rd_req, busy, grant_id,
               timeout_err});
    end else passed++;
    total++;
    if ({m_wr_addr, m_rd_addr, m_wr_burst_len, m_rd_burst_len} !== 68'd0) begin
      $display("FAIL reset_attr: got %h %h want 0", m_wr_addr, m_rd_addr);
    end else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b want 0", busy);
    else passed++;
    mrr = 0;
  endtask

  task automatic test_single_p0w();
    bit found, is_rd; int lat, g, bad; logic [23:0] a; logic [9:0] l;
    addr_v[0] = 24'h000100; len_v[0] = 10'd256; req_v = 4'b0001;
    run_burst(2, 4, found, lat, g, is_rd, a, l, bad);
    req_v = '0;
    total++;
    if (!found || lat != 1) $display("FAIL p0w_latency: found=%0d lat=%0d want 1", found, lat);
    else passed++;
    total++;
    if (g != 0 || is_rd) $display("FAIL p0w_grant: got %0d rd=%0d want 0 wr", g, is_rd);
    else passed++;
    total++;
    if (a !== 24'h000100 || l !== 10'd256)
      $display("FAIL p0w_attr: got %h/%0d want 000100/256", a, l);
    else passed++;
    total++;
    if (bad != 0) $display("FAIL p0w_route_hold: violations=%0d want 0", bad);
    else passed++;
    mrr = 1;
  endtask

  task automatic test_all_four();
    bit found, is_rd; int lat, g, bad, exp_g; logic [23:0] a; logic [9:0] l;
    repeat (2) @(negedge clk);
    req_v = 4'b1111;
    for (int n = 0; n < 7; n++) begin
      if (n == 5) req_v = 4'b0101;
      exp_g = pick(req_v, mrr);
      run_burst(n % 3, 3, found, lat, g, is_rd, a, l, bad);
      if (n == 6) req_v = '0;
      total++;
      if (!found || g != exp_g || is_rd != exp_g[0])
        $display("FAIL rr_order[%0d]: got %0d want %0d", n, g, exp_g);
      else passed++;
      total++;
      if (lat != ((n == 0) ? 1 : 2) || bad != 0)
        $display("FAIL rr_gap[%0d]: lat=%0d bad=%0d want lat %0d bad 0", n, lat, bad,
                 (n == 0) ? 1 : 2);
      else passed++;
      mrr = (exp_g + 1) % 4;
    end
  endtask

  task automatic test_abort_drop();
    bit found, is_rd; int lat, g, bad, exp_g; logic [23:0] a; logic [9:0] l;
    repeat (2) @(negedge clk);
    req_v = 4'b0001;
    @(negedge clk);
    total++;
    if (m_wr_req !== 1'b1) $display("FAIL drop_req_up: got %b want 1", m_wr_req);
    else passed++;
    @(negedge clk);
    req_v = '0;
    @(negedge clk);
    total++;
    if ({m_wr_req, busy, timeout_err} !== 3'b000)
      $display("FAIL drop_abort: got %b want 000", {m_wr_req, busy, timeout_err});
    else passed++;
    req_v = 4'b1111;
    exp_g = pick(req_v, mrr);
    run_burst(1, 3, found, lat, g, is_rd, a, l, bad);
    req_v = '0;
    total++;
    if (!found || g != exp_g) $display("FAIL drop_rr_kept: got %0d want %0d", g, exp_g);
    else passed++;
    mrr = (exp_g + 1) % 4;
  endtask

  task automatic test_timeout();
    bit found, is_rd; int lat, g, bad, exp_g, rd_hi, te; logic [23:0] a; logic [9:0] l;
    repeat (2) @(negedge clk);
    req_v = 4'b0100;
    run_burst(0, 3, found, lat, g, is_rd, a, l, bad);
    req_v = '0;
    total++;
    if (!found || g != 2) $display("FAIL to_setup_grant: got %0d want 2", g);
    else passed++;
    mrr = 3;
    repeat (2) @(negedge clk);
    req_v = 4'b1000; rd_hi = 0; te = 0; bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_rd_req) begin
        rd_hi++;
        if (grant_id !== 2'd3) bad++;
      end
      if (m_wr_req) bad++;
      if (p1_rd_ack) bad++;
      if (timeout_err) begin
        te++;
        req_v = '0;
      end
    end
    total++;
    if (rd_hi != 15) $display("FAIL to_req_cycles: got %0d want 15", rd_hi);
    else passed++;
    total++;
    if (te != 1 || bad != 0) $display("FAIL to_pulse: pulses=%0d bad=%0d want 1/0", te, bad);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL to_idle: busy=%b want 0", busy);
    else passed++;
    req_v = 4'b1111;
    exp_g = pick(req_v, mrr);
    run_burst(0, 3, found, lat, g, is_rd, a, l, bad);
    req_v = '0;
    total++;
    if (!found || g != exp_g || exp_g != 3) $display("FAIL to_rr_kept: got %0d want 3", g);
    else passed++;
    mrr = (exp_g + 1) % 4;
  endtask

  task automatic test_random();
    bit found, is_rd; int lat, g, bad, exp_g; logic [23:0] a, exp_a; logic [9:0] l, exp_l;
    repeat (2) @(negedge clk);
    req_v = 4'($urandom_range(1, 15));
    for (int n = 0; n < 12; n++) begin
      exp_g = pick(req_v, mrr);
      exp_a = addr_v[exp_g];
      exp_l = len_v[exp_g];
      run_burst(int'($urandom_range(0, 3)), int'($urandom_range(3, 6)), found, lat, g, is_rd,
                a, l, bad);
      // Re-arm the clients during REL; the next IDLE arbitration sees the new set.
      for (int i = 0; i < 4; i++) begin
        addr_v[i] = 24'($urandom);
        len_v[i]  = 10'($urandom);
      end
      req_v = (n == 11) ? 4'b0000 : 4'($urandom_range(1, 15));
      total++;
      if (!found || g != exp_g || a !== exp_a || l !== exp_l || bad != 0)
        $display("FAIL rand[%0d]: grant %0d addr %h len %0d bad %0d want %0d %h %0d 0", n, g,
                 a, l, bad, exp_g, exp_a, exp_l);
      else passed++;
      mrr = (exp_g + 1) % 4;
    end
  endtask

  task automatic test_reset_mid_burst();
    int bad;
    repeat (2) @(negedge clk);
    req_v = 4'b0001;
    @(negedge clk);
    m_wr_ack = 1'b1;
    @(negedge clk);
    total++;
    if (p0_wr_ack !== 1'b1) $display("FAIL rst_pre_ack: got %b want 1", p0_wr_ack);
    else passed++;
    rst_n = 1'b0;
    req_v = '0;
    #1;
    total++;
    if ({m_wr_req, m_rd_req, busy, grant_id, timeout_err, p0_wr_ack, p0_rd_ack, p1_wr_ack,
         p1_rd_ack} !== 11'd0 || m_wr_addr !== 24'd0)
      $display("FAIL rst_mid_outputs: busy=%b ack=%b addr=%h want 0", busy, p0_wr_ack,
               m_wr_addr);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({p0_wr_ack, p0_rd_ack, p1_wr_ack, p1_rd_ack} !== 4'b0000 || busy) bad++;
    end
    m_wr_ack = 1'b0;
    total++;
    if (bad != 0) $display("FAIL rst_stray_ack: violations=%0d want 0", bad);
    else passed++;
    mrr = 0;
  endtask

  initial begin
    test_reset();
    test_single_p0w();
    test_all_four();
    test_abort_drop();
    test_timeout();
    test_random();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
